// File: rtl/uart_tx_arbiter_if.sv
// Bundle between message sources, the packet arbiter and the uart_tx byte interface.
// master = sources plus the UART side; slave = the arbiter itself.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    logic [7:0]           tx_data;
    logic                 tx_start;
    logic                 tx_busy;
    logic                 timeout_pulse;

    modport master (
        output req_data, req_valid, req_last, tx_busy,
        input  req_ready, grant, tx_data, tx_start, timeout_pulse
    );

    modport slave (
        input  req_data, req_valid, req_last, tx_busy,
        output req_ready, grant, tx_data, tx_start, timeout_pulse
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one uart_tx among NUM_REQ byte sources.
// A grant covers a whole packet; a watchdog reclaims the UART from a stalled owner.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {ST_ARB, ST_LOAD, ST_WAIT_BUSY, ST_WAIT_DONE} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               timeout_q, timeout_d;
    logic               last_q, last_d;
    logic               fb_q, fb_d;
    logic [WD_W-1:0]    wd_q, wd_d;

    logic               arb_hit;
    logic [IDX_W-1:0]   arb_idx;
    logic [IDX_W-1:0]   cand;
    logic               own_valid;
    logic               own_last;
    logic [7:0]         own_byte;
    logic [WD_W-1:0]    wd_inc;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
        return (int'(v) == NUM_REQ - 1) ? '0 : v + 1'b1;
    endfunction

    // First valid requester at or after rr_ptr, searching upward with wrap-around.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        cand    = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!arb_hit && bus.req_valid[cand]) begin
                arb_hit = 1'b1;
                arb_idx = cand;
            end
            cand = wrap_inc(cand);
        end
    end

    assign own_valid = bus.req_valid[owner_q];
    assign own_last  = bus.req_last[owner_q];
    assign own_byte  = bus.req_data[8*int'(owner_q) +: 8];
    assign wd_inc    = wd_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        timeout_d  = 1'b0;
        last_d     = last_q;
        fb_d       = fb_q;
        wd_d       = wd_q;
        case (state_q)
            ST_ARB: begin
                wd_d    = '0;
                grant_d = '0;
                if (arb_hit) begin
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << arb_idx;
                    owner_d = arb_idx;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Acceptance wins over a watchdog expiry in the same cycle.
                if (own_valid) begin
                    tx_data_d  = own_byte;
                    tx_start_d = 1'b1;
                    last_d     = own_last;
                    wd_d       = '0;
                    fb_d       = 1'b0;
                    state_d    = ST_WAIT_BUSY;
                end else if (wd_inc == WD_LIMIT) begin
                    timeout_d = 1'b1;
                    grant_d   = '0;
                    rr_ptr_d  = wrap_inc(owner_q);
                    wd_d      = '0;
                    state_d   = ST_ARB;
                end else begin
                    wd_d = wd_inc;
                end
            end
            ST_WAIT_BUSY: begin
                // Second cycle here moves on even without a busy edge.
                if (bus.tx_busy || fb_q) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    fb_d = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (last_q) begin
                        rr_ptr_d = wrap_inc(owner_q);
                        grant_d  = '0;
                        state_d  = ST_ARB;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ARB;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            timeout_q  <= 1'b0;
            last_q     <= 1'b0;
            fb_q       <= 1'b0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            timeout_q  <= timeout_d;
            last_q     <= last_d;
            fb_q       <= fb_d;
            wd_q       <= wd_d;
        end
    end

    assign bus.req_ready     = (state_q == ST_LOAD && own_valid) ? grant_q : '0;
    assign bus.grant         = grant_q;
    assign bus.tx_data       = tx_data_q;
    assign bus.tx_start      = tx_start_q;
    assign bus.timeout_pulse = timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-based sources, a uart_tx busy model and a
// packet-level round-robin reference model predicting the serial byte order.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ        = 4;
    localparam int TIMEOUT_CYCLES = 50;
    typedef logic [8:0] sym_t;  // {last, byte}

    logic clk = 1'b0;
    logic rst;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    sym_t               src_q [NUM_REQ][$];
    logic [10:0]        exp_q[$];
    logic [10:0]        obs_q[$];
    int                 gap_q[$];
    logic [NUM_REQ-1:0] src_en, s_ready, s_grant, s_valid, grant_or;
    logic [7:0]         s_data;
    logic               s_start, s_busy, s_tmo, prev_start, prev_busy;
    int                 checks, failures, cyc, last_fall, busy_left, busy_len, tmo_cnt;
    logic [7:0]         msg [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] owner_of(input logic [NUM_REQ-1:0] g);
        logic [2:0] r;
        r = 3'd7;
        for (int i = NUM_REQ - 1; i >= 0; i--) if (g[i]) r = 3'(i);
        return r;
    endfunction

    function automatic bit pending();
        bit p;
        p = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) if (src_en[i] && src_q[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic drive_sources();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_en[i] && src_q[i].size() > 0) begin
                bus.req_valid[i]        = 1'b1;
                bus.req_data[8*i +: 8]  = src_q[i][0][7:0];
                bus.req_last[i]         = src_q[i][0][8];
            end else begin
                bus.req_valid[i] = 1'b0;
                bus.req_last[i]  = 1'b0;
            end
        end
    endtask

    // One clock: apply inputs after the edge, sample outputs on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++)
            if (s_ready[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (s_start) busy_left = busy_len;
        else if (busy_left > 0) busy_left--;
        bus.tx_busy = (busy_left > 0);
        drive_sources();
        @(negedge clk);
        cyc++;
        prev_start = s_start;
        prev_busy  = s_busy;
        s_ready = bus.req_ready;
        s_grant = bus.grant;
        s_valid = bus.req_valid;
        s_start = bus.tx_start;
        s_data  = bus.tx_data;
        s_busy  = bus.tx_busy;
        s_tmo   = bus.timeout_pulse;
        grant_or |= s_grant;
        if (s_tmo) tmo_cnt++;
        if (prev_busy && !s_busy) last_fall = cyc;
        if (s_ready != '0) check("ready_owner", s_ready, s_grant & s_valid);
        if (s_start) begin
            check("start_gap", prev_start, 0);
            check("start_idle", s_busy, 0);
            obs_q.push_back({owner_of(s_grant), s_data});
            gap_q.push_back(cyc - last_fall);
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        src_en = '0;
        for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, s_grant, 0);
        check({tag, "_start"}, s_start, 0);
        check({tag, "_data"},  s_data, 0);
        check({tag, "_tmo"},   s_tmo, 0);
        check({tag, "_ready"}, s_ready, 0);
    endtask

    task automatic push_packet(input int i, input int len);
        for (int k = 0; k < len; k++)
            src_q[i].push_back({(k == len - 1), 8'($urandom_range(0, 255))});
    endtask

    // Whole packets, served round-robin from a pointer that starts at 0 and
    // moves just past each finished owner.
    task automatic build_expected(input logic [NUM_REQ-1:0] en);
        sym_t m [NUM_REQ][$];
        sym_t s;
        int   ptr, sel;
        exp_q.delete();
        for (int i = 0; i < NUM_REQ; i++) if (en[i]) m[i] = src_q[i];
        ptr = 0;
        for (int guard = 0; guard < 1000; guard++) begin
            sel = -1;
            for (int k = 0; k < NUM_REQ; k++)
                if (sel < 0 && m[(ptr + k) % NUM_REQ].size() > 0) sel = (ptr + k) % NUM_REQ;
            if (sel < 0) break;
            do begin
                s = m[sel].pop_front();
                exp_q.push_back({3'(sel), s[7:0]});
            end while (!s[8] && m[sel].size() > 0);
            ptr = (sel + 1) % NUM_REQ;
        end
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((pending() || s_grant != '0 || s_busy) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, (n < budget), 1);
        check({tag, "_len"}, obs_q.size(), exp_q.size());
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++)
            check({tag, "_byte"}, obs_q[k], exp_q[k]);
    endtask

    initial begin
        int n, np, len;
        msg = '{8'h31, 8'h32, 8'h33, 8'h20, 8'h48, 8'h7A, 8'h0D, 8'h0A};
        rst = 1'b1;
        bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.tx_busy = 1'b0;
        src_en = '0; checks = 0; failures = 0; cyc = 0; last_fall = 0;
        busy_left = 0; busy_len = 4; tmo_cnt = 0; grant_or = '0;
        s_ready = '0; s_grant = '0; s_valid = '0; s_data = '0;
        s_start = 1'b0; s_busy = 1'b0; s_tmo = 1'b0; prev_start = 1'b0; prev_busy = 1'b0;

        do_reset();
        check_reset_outputs("rst");

        // Single 8-byte line on requester 0 with latency and inter-byte spacing.
        busy_len = 6;
        for (int k = 0; k < 8; k++) src_q[0].push_back({(k == 7), msg[k]});
        build_expected(4'b0001);
        obs_q.delete(); gap_q.delete(); grant_or = '0;
        src_en = 4'b0001;
        tick();
        check("t1_valid_n", s_valid, 4'b0001);
        check("t1_grant_n", s_grant, 0);
        tick();
        check("t1_grant_n1", s_grant, 4'b0001);
        check("t1_ready_n1", s_ready, 4'b0001);
        tick();
        check("t1_start_n2", s_start, 1);
        check("t1_data_n2", s_data, 8'h31);
        run_until_idle("t1", 2000);
        check("t1_grant_or", grant_or, 4'b0001);
        check("t1_grant_end", s_grant, 0);
        check("t1_starts", gap_q.size(), 8);
        for (int k = 1; k < gap_q.size(); k++) check("t1_gap", gap_q[k], 2);

        // Requesters 0 and 2 with two 3-byte packets each.
        do_reset(); busy_len = 3;
        push_packet(0, 3); push_packet(0, 3); push_packet(2, 3); push_packet(2, 3);
        build_expected(4'b0101);
        obs_q.delete(); src_en = 4'b0101;
        run_until_idle("t2", 2000);

        // All four with 1-byte packets; requester 0 has a second one.
        do_reset(); busy_len = 2;
        push_packet(0, 1); push_packet(0, 1); push_packet(1, 1); push_packet(2, 1); push_packet(3, 1);
        build_expected(4'b1111);
        obs_q.delete(); src_en = 4'b1111;
        run_until_idle("t3", 2000);
        check("t3_order", {obs_q[0][10:8], obs_q[1][10:8], obs_q[2][10:8], obs_q[3][10:8], obs_q[4][10:8]},
              {3'd0, 3'd1, 3'd2, 3'd3, 3'd0});

        // Requester 1 stalls mid-packet while requester 2 waits.
        do_reset(); busy_len = 5;
        src_q[1].push_back({1'b0, 8'hA1}); src_q[1].push_back({1'b0, 8'hA2});
        src_q[2].push_back({1'b1, 8'hC3});
        exp_q.delete();
        exp_q.push_back({3'd1, 8'hA1}); exp_q.push_back({3'd1, 8'hA2}); exp_q.push_back({3'd2, 8'hC3});
        obs_q.delete(); tmo_cnt = 0; src_en = 4'b0110;
        n = 0;
        while (!s_tmo && n < 400) begin tick(); n++; end
        check("t4_tmo_seen", s_tmo, 1);
        check("t4_tmo_delay", cyc - last_fall, TIMEOUT_CYCLES);
        check("t4_grant_clr", s_grant, 0);
        tick();
        check("t4_tmo_width", s_tmo, 0);
        check("t4_next_grant", s_grant, 4'b0100);
        run_until_idle("t4", 2000);
        check("t4_tmo_count", tmo_cnt, 1);

        // Reset while waiting for a mid-packet byte to finish.
        do_reset(); busy_len = 6;
        src_q[1].push_back({1'b1, 8'h11});
        for (int k = 0; k < 3; k++) src_q[3].push_back({(k == 2), 8'(48 + k)});
        obs_q.delete(); src_en = 4'b1010;
        n = 0;
        while (obs_q.size() < 3 && n < 400) begin tick(); n++; end
        check("t5_bytes_before", obs_q.size(), 3);
        tick(); tick();
        check("t5_busy_mid", s_busy, 1);
        rst = 1'b1; src_en = '0;
        tick();
        rst = 1'b0;
        check_reset_outputs("t5_rst");
        n = 0;
        while (s_busy && n < 100) begin tick(); n++; end
        src_q[0].push_back({1'b0, 8'h55}); src_q[0].push_back({1'b1, 8'h66});
        build_expected(4'b1001);
        obs_q.delete(); src_en = 4'b1001;
        run_until_idle("t5", 2000);

        // uart_tx busy for a single cycle per byte.
        do_reset(); busy_len = 1;
        push_packet(2, 4); push_packet(0, 2);
        build_expected(4'b0101);
        obs_q.delete(); src_en = 4'b0101;
        run_until_idle("t6", 2000);

        // Randomized packet mixes and UART speeds.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            busy_len = $urandom_range(1, 8);
            for (int i = 0; i < NUM_REQ; i++) begin
                np = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 3);
                for (int p = 0; p < np; p++) begin
                    len = $urandom_range(1, 5);
                    push_packet(i, len);
                end
            end
            build_expected('1);
            obs_q.delete(); tmo_cnt = 0; src_en = '1;
            run_until_idle("rnd", 6000);
            check("rnd_no_tmo", tmo_cnt, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-level round-robin arbiter that lets several message sources share one `uart_tx` instance. Examples of sources are the frequency-report formatter, a status reporter and a debug dump. Each source presents a byte stream with a last-byte marker. The arbiter grants the UART to one source for a whole line, so lines are never interleaved, and paces the bytes into `uart_tx` using `tx_start`/`tx_busy`. A watchdog releases the grant if a granted source stalls mid-packet.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 2_500_000: idle cycles allowed mid-packet before the grant is revoked (100 ms at 25 MHz); must be ≥ 2.
- `clk` in 1: system clock. One clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `req_data` in 8*NUM_REQ: byte from requester i on bits [8i+7:8i].
- `req_valid` in NUM_REQ: requester i has a byte available.
- `req_last` in NUM_REQ: the byte offered by requester i ends its packet.
- `req_ready` out NUM_REQ: byte accepted from requester i this cycle. Combinational, one-hot or zero.
- `grant` out NUM_REQ: registered, one-hot owner of the UART, or zero when unowned.
- `tx_data` out 8: byte to `uart_tx`.
- `tx_start` out 1: one-cycle start pulse to `uart_tx`.
- `tx_busy` in 1: from `uart_tx`. Rises the cycle after `tx_start` and stays high until the stop bit completes.
- `timeout_pulse` out 1: one-cycle pulse when a grant is revoked by the watchdog.

## Operation
- States: ST_ARB, ST_LOAD, ST_WAIT_BUSY, ST_WAIT_DONE.
- ST_ARB:
  - If any `req_valid` bit is set, grant the first index at or after `rr_ptr` (searching upward with wrap-around) whose valid is high.
  - Register that index into `grant` and go to ST_LOAD.
  - Otherwise stay in ST_ARB with `grant` = 0.
- ST_LOAD, owner g:
  - If `req_valid[g]`:
    - `req_ready[g]` = 1.
    - Register `tx_data` = byte g and `tx_start` = 1.
    - Capture `last_r` = `req_last[g]`.
    - Clear the watchdog and go to ST_WAIT_BUSY.
  - Else increment the watchdog. When it reaches TIMEOUT_CYCLES-1:
    - pulse `timeout_pulse`;
    - set `grant` = 0 and `rr_ptr` = g+1 mod NUM_REQ;
    - go to ST_ARB.
- ST_WAIT_BUSY: wait for `tx_busy` = 1, then go to ST_WAIT_DONE.
  - A fallback counter of 2 cycles also advances to ST_WAIT_DONE, so a missed busy edge cannot deadlock the arbiter.
- ST_WAIT_DONE: wait for `tx_busy` = 0, then:
  - if `last_r` = 1: set `rr_ptr` = g+1 mod NUM_REQ, set `grant` = 0, go to ST_ARB;
  - otherwise go to ST_LOAD.
- Round-robin fairness:
  - The pointer advances only past the owner that just finished or timed out.
  - A requester with valid continuously high waits at most NUM_REQ-1 other packets.
- Non-granted requesters: `req_valid` and `req_data` are ignored and `req_ready` = 0. Their sources must hold their byte stable.
- Owner's `req_valid`: may drop mid-packet without penalty until the watchdog expires.
- After a timeout, the remainder of the abandoned packet is treated as a new packet on the next grant. The source is responsible for resync.

## Timing
- Reset values:
  - state ST_ARB;
  - `grant` 0, `req_ready` 0, `tx_start` 0, `tx_data` 0x00, `timeout_pulse` 0;
  - `rr_ptr` 0, `last_r` 0, watchdog 0.
- Reset mid-transfer returns to ST_ARB immediately. The byte already in `uart_tx` completes on the line, and the next byte is not issued until a new grant exists.
- Latency, idle to first start: `req_valid` high in cycle N (ST_ARB) → `grant` valid in N+1 → `req_ready` high in N+1 → `tx_start` high in N+2.
- Between bytes of one packet: `tx_busy` falls in cycle M → ST_LOAD in M+1 → `tx_start` in M+2.
- `tx_start` is never high in two consecutive cycles. It is never asserted while `tx_busy` = 1.
- Simultaneous requests in ST_ARB: resolved solely by `rr_ptr`. Lower index wins only if it is at or after the pointer.
- `req_last` on the only byte (1-byte packet): the grant is released after that byte.
- Timeout and a `req_valid` arriving in the same cycle: the byte is accepted and no timeout fires, because acceptance takes priority.

## Test plan
- Single requester 0 sends "123 Hz\r\n" (8 bytes, last on 0x0A):
  - exactly 8 `tx_start` pulses, bytes in order;
  - `grant` = 0001 throughout, then 0000;
  - first `tx_start` 2 cycles after `req_valid`.
- Requesters 0 and 2 both valid from reset with 3-byte packets, repeated:
  - serial order is packet0, packet2, packet0, packet2;
  - no byte of one packet appears between bytes of another.
- All four requesters continuously valid with 1-byte packets: grant sequence 0,1,2,3,0.
- Requester 1 sends 2 bytes without last, then drops valid (TIMEOUT_CYCLES = 50):
  - `timeout_pulse` 50 cycles after the last byte completes;
  - `grant` cleared;
  - pending requester 2 granted next cycle.
- Assert `rst` for 1 cycle while in ST_WAIT_DONE mid-packet:
  - all outputs return to reset values;
  - next arbitration starts from `rr_ptr` = 0.
- Bench `uart_tx` model holds `tx_busy` for exactly 1 cycle after start:
  - no double `tx_start`;
  - packet completes correctly.
